fetch_redirect_ctrl: RTL

Sequencer between the next-PC selection logic and the PF stage. It captures redirect requests from four sources: ERET, exception, TLB/cache-op refetch and branch mispredict. It resolves their priority, holds the winning target until PF can accept it, and squashes stale branch redirects in the cycle after a redirect is taken. The next-PC mux uses `redirect_valid`/`redirect_pc` in place of its sequential PC when asserted.

---
 rtl/fetch_redirect_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Redirect sequencer between next-PC selection and PF: prioritises ERET/exception/
// refetch/branch redirects, holds the winner until PF accepts, and squashes stale branches.
module fetch_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        eret_req,
  input  logic [31:0] eret_target,
  input  logic        exc_req,
  input  logic [31:0] exc_vector,
  input  logic        refetch_req,
  input  logic [31:0] refetch_pc,
  input  logic        bj_req,
  input  logic [31:0] bj_target,
  input  logic        pf_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  redirect_src,
  output logic        flush_front,
  output logic [7:0]  wait_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        redirect_valid_r, valid_s;
  logic [31:0] redirect_pc_r, pc_s;
  logic [1:0]  redirect_src_r, src_s;
  logic        flush_front_r, flush_s;
  logic [7:0]  wait_cnt_r, wcnt_s;

  logic        req_any_s;
  logic        req_nonbj_s;
  logic [1:0]  win_src_s;
  logic [31:0] win_pc_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc = 8'hFF;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

  // Fixed-priority selection of the winning request; lower src code wins.
  always_comb begin
    win_src_s   = 2'd3;
    win_pc_s    = bj_target;
    req_any_s   = 1'b0;
    req_nonbj_s = 1'b0;
    if (eret_req) begin
      win_src_s   = 2'd0;
      win_pc_s    = eret_target;
      req_any_s   = 1'b1;
      req_nonbj_s = 1'b1;
    end else if (exc_req) begin
      win_src_s   = 2'd1;
      win_pc_s    = exc_vector;
      req_any_s   = 1'b1;
      req_nonbj_s = 1'b1;
    end else if (refetch_req) begin
      win_src_s   = 2'd2;
      win_pc_s    = refetch_pc;
      req_any_s   = 1'b1;
      req_nonbj_s = 1'b1;
    end else if (bj_req) begin
      req_any_s   = 1'b1;
      req_nonbj_s = 1'b0;
    end else begin
      req_any_s   = 1'b0;
      req_nonbj_s = 1'b0;
    end
  end

  // Next-state and next-output computation for the redirect FSM.
  always_comb begin
    state_s = state_r;
    valid_s = redirect_valid_r;
    pc_s    = redirect_pc_r;
    src_s   = redirect_src_r;
    flush_s = 1'b0;
    wcnt_s  = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_s = ST_PEND;
          valid_s = 1'b1;
          pc_s    = win_pc_s;
          src_s   = win_src_s;
          flush_s = 1'b1;
          wcnt_s  = 8'd0;
        end else begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
        end
      end
      ST_PEND: begin
        if (pf_ready) begin
          // A branch arriving with the acceptance is stale and is dropped here.
          if (req_nonbj_s) begin
            state_s = ST_PEND;
            valid_s = 1'b1;
            pc_s    = win_pc_s;
            src_s   = win_src_s;
            flush_s = 1'b1;
            wcnt_s  = 8'd0;
          end else begin
            state_s = ST_SQUASH;
            valid_s = 1'b0;
          end
        end else begin
          wcnt_s = sat_inc(wait_cnt_r);
          if (req_any_s && (win_src_s < redirect_src_r)) begin
            pc_s    = win_pc_s;
            src_s   = win_src_s;
            flush_s = 1'b1;
          end else begin
            flush_s = 1'b0;
          end
        end
      end
      ST_SQUASH: begin
        if (req_nonbj_s) begin
          state_s = ST_PEND;
          valid_s = 1'b1;
          pc_s    = win_pc_s;
          src_s   = win_src_s;
          flush_s = 1'b1;
          wcnt_s  = 8'd0;
        end else begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
      redirect_src_r   <= 2'd0;
      flush_front_r    <= 1'b0;
      wait_cnt_r       <= 8'd0;
    end else begin
      state_r          <= state_s;
      redirect_valid_r <= valid_s;
      redirect_pc_r    <= pc_s;
      redirect_src_r   <= src_s;
      flush_front_r    <= flush_s;
      wait_cnt_r       <= wcnt_s;
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign redirect_src   = redirect_src_r;
  assign flush_front    = flush_front_r;
  assign wait_cnt       = wait_cnt_r;

endmodule
